// File: rtl/if_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_stage
// Purpose  : Instruction-fetch stage of the 5-stage MIPS core. Issues word
//            fetches over a request/response memory handshake, buffers the
//            returned words in a small prefetch FIFO and loads one
//            instruction per cycle into the IF/ID register. Honours the
//            decode stall and flushes everything on a branch/jump redirect.
// Ports    : clock, reset_n            - clock, async active-low reset
//            imem_req/addr/ready       - fetch request channel
//            imem_rvalid/rdata         - in-order fetch response channel
//            stall                     - hold IF/ID (load-use hazard)
//            redirect, redirect_pc     - taken branch/jump, new fetch address
//            ifid_ir/pc/valid          - IF/ID pipeline register
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] ifid_ir,
   output logic [31:0] ifid_pc,
   output logic        ifid_valid
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = c_AW + 1;
   localparam logic [c_CW:0] c_CREDIT = DEPTH[c_CW:0];
   localparam logic [c_CW-1:0] c_FULL = DEPTH[c_CW-1:0];

   logic [31:0]     r_fetch_pc;
   logic [31:0]     r_resp_pc;
   logic [c_CW-1:0] r_outstanding;
   logic [c_CW-1:0] r_drop;
   logic [c_CW-1:0] r_count;
   logic [c_AW-1:0] r_wptr;
   logic [c_AW-1:0] r_rptr;
   logic [31:0]     r_mem_ir [DEPTH];
   logic [31:0]     r_mem_pc [DEPTH];

   logic            w_accept;
   logic            w_discard;
   logic            w_push;
   logic            w_pop;
   logic            w_empty;
   logic [c_CW:0]   w_inflight;
   logic [31:0]     w_redirect_pc;
   logic            w_unused_pc_bits;

   // Credit: buffered words plus live requests never exceed the FIFO size,
   // so every live response is guaranteed a free slot. Dropped (stale)
   // responses never push and therefore consume no credit.
   assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding};
   assign imem_req   = reset_n && !redirect && (w_inflight < c_CREDIT);
   assign imem_addr  = r_fetch_pc;
   assign w_accept   = imem_req && imem_ready;

   // A response in the redirect cycle belongs to the flushed stream.
   assign w_discard  = imem_rvalid && (redirect || (r_drop != '0));
   assign w_push     = imem_rvalid && !w_discard;
   assign w_empty    = (r_count == '0);
   assign w_pop      = !redirect && !stall && !w_empty;

   assign w_redirect_pc    = {redirect_pc[31:2], 2'b00};
   assign w_unused_pc_bits = ^redirect_pc[1:0];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_drop        <= '0;
         r_count       <= '0;
         r_wptr        <= '0;
         r_rptr        <= '0;
         ifid_ir       <= NOP;
         ifid_pc       <= 32'h0000_0000;
         ifid_valid    <= 1'b0;
      end else if (redirect) begin
         r_fetch_pc    <= w_redirect_pc;
         r_resp_pc     <= w_redirect_pc;
         // Everything still in flight becomes stale; a coincident response
         // retires one of those stale words immediately.
         r_drop        <= r_drop + r_outstanding - c_CW'(imem_rvalid);
         r_outstanding <= '0;
         r_count       <= '0;
         r_wptr        <= '0;
         r_rptr        <= '0;
         ifid_ir       <= NOP;
         ifid_valid    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         if (w_push) begin
            r_resp_pc <= r_resp_pc + 32'd4;
            r_wptr    <= r_wptr + c_AW'(1);
         end
         if (imem_rvalid && (r_drop != '0)) begin
            r_drop <= r_drop - c_CW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_AW'(1);
         end
         r_outstanding <= r_outstanding + c_CW'(w_accept) - c_CW'(w_push);
         r_count       <= r_count + c_CW'(w_push) - c_CW'(w_pop);

         if (!stall) begin
            if (!w_empty) begin
               ifid_ir    <= r_mem_ir[r_rptr];
               ifid_pc    <= r_mem_pc[r_rptr];
               ifid_valid <= 1'b1;
            end else begin
               ifid_ir    <= NOP;
               ifid_valid <= 1'b0;
            end
         end
      end
   end

   // FIFO storage carries no reset; occupancy is tracked by r_count.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem_ir[r_wptr] <= imem_rdata;
         r_mem_pc[r_wptr] <= r_resp_pc;
      end
   end

   // The credit scheme makes a push into a full FIFO impossible.
   always_ff @(posedge clock) begin
      if (reset_n) begin
         assert (!(w_push && (r_count == c_FULL)));
      end
   end

endmodule
`default_nettype wire
